// File: rtl/dsp_channel_scheduler.sv
// Round-robin scheduler sharing one filter engine across N_CH sample channels.
// Optional DSP_SCHED_STATS_EN adds served_cnt / drop_cnt statistics outputs.
module dsp_channel_scheduler #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              ch_valid,
    input  logic [N_CH*SAMPLE_WIDTH-1:0] ch_sample,
    input  logic [N_CH*2-1:0]            ch_mode,
    output logic [N_CH-1:0]              ch_accept,
    output logic [N_CH-1:0]              res_valid,
    output logic [SAMPLE_WIDTH-1:0]      res_data,
    output logic                         eng_sample_valid,
    output logic [SAMPLE_WIDTH-1:0]      eng_sample_in,
    output logic [1:0]                   eng_filter_mode,
    input  logic [SAMPLE_WIDTH-1:0]      eng_sample_out,
    input  logic                         eng_sample_ready,
    output logic                         busy,
    output logic [2:0]                   grant_id,
    output logic                         timeout_err
`ifdef DSP_SCHED_STATS_EN
    ,
    output logic [15:0]                  served_cnt,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int unsigned ID_W = 3;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [WD_W-1:0]         wd_cnt;

    logic [ID_W-1:0]         pick_c;
    logic                    pick_found_c;
    logic [SAMPLE_WIDTH-1:0] pick_sample_c;
    logic [1:0]              pick_mode_c;
    logic [ID_W-1:0]         rr_next_c;
    int                      best_dist_c;
    int                      dist_c;

    // Closest requester at or after rr_ptr (distance measured modulo N_CH).
    always_comb begin
        pick_c        = '0;
        pick_found_c  = 1'b0;
        pick_sample_c = '0;
        pick_mode_c   = '0;
        best_dist_c   = int'(N_CH);
        dist_c        = 0;
        for (int i = 0; i < int'(N_CH); i++) begin
            dist_c = (i + int'(N_CH) - int'(rr_ptr)) % int'(N_CH);
            if (ch_valid[i] && (dist_c < best_dist_c)) begin
                best_dist_c   = dist_c;
                pick_c        = ID_W'(i);
                pick_found_c  = 1'b1;
                pick_sample_c = ch_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                pick_mode_c   = ch_mode[i*2 +: 2];
            end
        end
    end

    assign rr_next_c = (grant_id >= ID_W'(N_CH - 1)) ? '0 : grant_id + ID_W'(1);

    // Outputs are registered on the transition edge, so each strobe is
    // visible during the state that follows the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            wd_cnt           <= '0;
            grant_id         <= '0;
            ch_accept        <= '0;
            res_valid        <= '0;
            res_data         <= '0;
            eng_sample_valid <= 1'b0;
            eng_sample_in    <= '0;
            eng_filter_mode  <= '0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
`ifdef DSP_SCHED_STATS_EN
            served_cnt       <= '0;
            drop_cnt         <= '0;
`endif
        end else begin
            ch_accept        <= '0;
            res_valid        <= '0;
            eng_sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found_c) begin
                        ch_accept       <= N_CH'(1) << pick_c;
                        eng_sample_in   <= pick_sample_c;
                        eng_filter_mode <= pick_mode_c;
                        grant_id        <= pick_c;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_sample_valid <= 1'b1;
                    wd_cnt           <= '0;
                    state            <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (eng_sample_ready) begin
                        res_data  <= eng_sample_out;
                        res_valid <= N_CH'(1) << grant_id;
                        state     <= RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= rr_next_c;
                        busy        <= 1'b0;
                        state       <= IDLE;
`ifdef DSP_SCHED_STATS_EN
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RESP: begin
                    rr_ptr <= rr_next_c;
                    busy   <= 1'b0;
                    state  <= IDLE;
`ifdef DSP_SCHED_STATS_EN
                    served_cnt <= served_cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dsp_channel_scheduler.md
Name: dsp_channel_scheduler

Overview:
- Round-robin scheduler that shares one filter engine (sample_valid / sample_in / filter_mode in; sample_out / sample_ready back) between N_CH independent sample channels.
- Grants one channel at a time and issues its sample and mode to the engine.
- Waits for the engine result, then routes it back to the owning channel.
- Sits between the channel front-ends and the DSP accelerator core. A watchdog recovers from an engine that never responds.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- SAMPLE_WIDTH, 16, sample/result width in bits.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for the engine in WAIT before aborting (>= 20).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ch_valid  input  N_CH  per-channel request; channel holds its sample/mode stable while high
- ch_sample  input  N_CH*SAMPLE_WIDTH  packed samples; channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- ch_mode  input  N_CH*2  packed filter modes; channel i at [i*2 +: 2]
- ch_accept  output  N_CH  one-hot, one-cycle pulse: request consumed
- res_valid  output  N_CH  one-hot, one-cycle pulse: result for channel i on res_data
- res_data  output  SAMPLE_WIDTH  result sample, valid with res_valid
- eng_sample_valid  output  1  one-cycle issue strobe to engine
- eng_sample_in  output  SAMPLE_WIDTH  sample to engine
- eng_filter_mode  output  2  mode to engine, held from ISSUE through WAIT
- eng_sample_out  input  SAMPLE_WIDTH  engine result
- eng_sample_ready  input  1  engine result strobe
- busy  output  1  high in any state other than IDLE
- grant_id  output  3  index of the current or last granted channel
- timeout_err  output  1  sticky; set on watchdog abort, cleared only by rst

Behaviour:
- Reset (rst high at clk edge):
  - State = IDLE, rr_ptr = 0, grant_id = 0.
  - All outputs 0: ch_accept, res_valid, res_data, eng_sample_valid, eng_sample_in, eng_filter_mode, busy, timeout_err.
  - A reset mid-transaction drops it silently; no res_valid is emitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If ch_valid is nonzero, grant the first set bit searching rr_ptr, rr_ptr+1, ... wrapping modulo N_CH.
  - Latch that channel's sample and mode into eng_sample_in and eng_filter_mode; set grant_id.
  - Pulse ch_accept[grant] in the same cycle; next state is ISSUE.
  - If ch_valid is zero, stay in IDLE.
- ISSUE: eng_sample_valid = 1 for exactly this cycle; clear the watchdog counter; next state is WAIT.
- WAIT:
  - Increment the watchdog each cycle.
  - If eng_sample_ready = 1, capture eng_sample_out into res_data and go to RESP.
  - Else, if the watchdog reaches TIMEOUT_CYCLES-1, set timeout_err, set rr_ptr = grant+1 mod N_CH, and go to IDLE with no res_valid.
  - If ready and the timeout coincide in the same cycle, ready wins.
- RESP: res_valid[grant] = 1 for one cycle; rr_ptr = grant+1 mod N_CH; next state is IDLE.
- A new grant is possible on the cycle after RESP.
- Latency:
  - ch_accept is asserted in the cycle ch_valid is first seen in IDLE.
  - eng_sample_valid follows one cycle after ch_accept.
  - res_valid follows one cycle after eng_sample_ready.
- eng_sample_ready seen outside WAIT is ignored.
- ch_valid changing while busy is legal. Only the IDLE-cycle snapshot is used for arbitration.
- res_data holds its last value until the next capture.
- Fairness: with all channels requesting, grants cycle 0,1,2,...,N_CH-1,0.

Optional Feature:
- Macro: DSP_SCHED_STATS_EN.
- Defined:
  - Adds output served_cnt [15:0], incremented on each RESP cycle and wrapping 0xFFFF -> 0.
  - Adds output drop_cnt [7:0], incremented on each watchdog abort and saturating at 0xFF.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single request: reset, then ch_valid = 4'b0100, ch_sample[2] = 16'h1234, ch_mode[2] = 2'b11.
  - ch_accept = 4'b0100 in the same cycle.
  - Next cycle: eng_sample_valid = 1, eng_sample_in = 16'h1234, eng_filter_mode = 2'b11.
  - Engine replies 16'hBEEF after 18 cycles: res_valid = 4'b0100 and res_data = 16'hBEEF one cycle later.
- Round-robin: ch_valid = 4'b1111 held, engine answering after 5 cycles each time.
  - Grant order 0,1,2,3,0.
  - Exactly one ch_accept bit per grant.
- Pointer wrap: after a channel-3 grant, ch_valid = 4'b1001 gives a grant to 0; a following ch_valid = 4'b1001 gives a grant to 3.
- Timeout: engine never asserts ready.
  - Abort after TIMEOUT_CYCLES = 64 cycles in WAIT: timeout_err = 1 and stays 1, no res_valid, busy = 0.
  - The next pending channel is then granted.
- Simultaneous ready and timeout at watchdog = 63: RESP is taken, res_valid pulses, timeout_err stays 0.
- Reset mid-WAIT: assert rst with the engine pending.
  - All outputs read 0 next cycle.
  - A late eng_sample_ready produces no res_valid.
  - With STATS enabled, served_cnt = 0.
